// File: rtl/dr_mem_responder.sv
// dr_mem_responder: fixed-latency, in-order memory model behind a directory bank's memory port.
// Optional macro DR_MEM_RESPONDER_PFREQ_EN queues prefetches as bandwidth-only slots that never ack.
module dr_mem_responder #(
  parameter int LAT       = 4,
  parameter int QDEPTH    = 4,
  parameter int MEM_LINES = 16,
  parameter int ACK_CODE  = 0,
  parameter int DRID_W    = 6,
  parameter int CMD_W     = 5,
  parameter int PADDR_W   = 50,
  parameter int LINE_W    = 512,
  parameter int ACK_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drtomem_req_valid,
  output logic               drtomem_req_retry,
  input  logic [DRID_W-1:0]  drtomem_req_drid,
  input  logic [CMD_W-1:0]   drtomem_req_cmd,
  input  logic [PADDR_W-1:0] drtomem_req_paddr,
  output logic               memtodr_ack_valid,
  input  logic               memtodr_ack_retry,
  output logic [DRID_W-1:0]  memtodr_ack_drid,
  output logic [ACK_W-1:0]   memtodr_ack_ack,
  output logic [LINE_W-1:0]  memtodr_ack_line,
  input  logic               drtomem_wb_valid,
  output logic               drtomem_wb_retry,
  input  logic [LINE_W-1:0]  drtomem_wb_line,
  input  logic [PADDR_W-1:0] drtomem_wb_paddr,
  input  logic               drtomem_pfreq_valid,
  output logic               drtomem_pfreq_retry,
  input  logic [PADDR_W-1:0] drtomem_pfreq_paddr
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [3:0]       LAT_INIT = 4'(LAT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam logic [ACK_W-1:0] ACK_VAL  = ACK_W'(ACK_CODE);

  logic [DRID_W-1:0] q_drid_q [QDEPTH];
  logic [DRID_W-1:0] q_drid_d [QDEPTH];
  logic [IDX_W-1:0]  q_idx_q  [QDEPTH];
  logic [IDX_W-1:0]  q_idx_d  [QDEPTH];
  logic              q_pf_q   [QDEPTH];
  logic              q_pf_d   [QDEPTH];
  logic [3:0]        q_cnt_q  [QDEPTH];
  logic [3:0]        q_cnt_d  [QDEPTH];
  logic [LINE_W-1:0] mem_q    [MEM_LINES];
  logic [LINE_W-1:0] mem_d    [MEM_LINES];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DRID_W-1:0] out_drid_q, out_drid_d;
  logic [LINE_W-1:0] out_line_q, out_line_d;

  logic              full, req_acc, pf_acc, push, pop;
  logic              head_rdy, head_pf, out_drain, wb_hit;
  logic [IDX_W-1:0]  head_idx, wb_idx;
  logic [LINE_W-1:0] rd_line;
  logic              unused_bits;

  always_comb begin
    full    = (count_q == FULL_CNT);
    req_acc = drtomem_req_valid && !full;
`ifdef DR_MEM_RESPONDER_PFREQ_EN
    pf_acc  = drtomem_pfreq_valid && !full && !drtomem_req_valid;
`else
    pf_acc  = 1'b0;
`endif
    push      = req_acc || pf_acc;
    head_pf   = q_pf_q[rd_ptr_q];
    head_idx  = q_idx_q[rd_ptr_q];
    head_rdy  = (count_q != '0) && (q_cnt_q[rd_ptr_q] == 4'd0);
    out_drain = out_valid_q && !memtodr_ack_retry;
    // Prefetch slots retire without touching the output register.
    pop       = head_rdy && (head_pf || !out_valid_q || out_drain);
    wb_idx    = drtomem_wb_paddr[6 +: IDX_W];
    wb_hit    = drtomem_wb_valid && (wb_idx == head_idx);
    rd_line   = wb_hit ? drtomem_wb_line : mem_q[head_idx];

    q_drid_d = q_drid_q;
    q_idx_d  = q_idx_q;
    q_pf_d   = q_pf_q;
    mem_d    = mem_q;
    for (int i = 0; i < QDEPTH; i++) begin
      q_cnt_d[i] = (q_cnt_q[i] != 4'd0) ? q_cnt_q[i] - 4'd1 : 4'd0;
    end
    if (push) begin
      q_drid_d[wr_ptr_q] = drtomem_req_drid;
      q_idx_d[wr_ptr_q]  = req_acc ? drtomem_req_paddr[6 +: IDX_W] : drtomem_pfreq_paddr[6 +: IDX_W];
      q_pf_d[wr_ptr_q]   = !req_acc;
      q_cnt_d[wr_ptr_q]  = LAT_INIT;
    end
    if (drtomem_wb_valid) begin
      mem_d[wb_idx] = drtomem_wb_line;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    out_valid_d = out_valid_q && !out_drain;
    out_drid_d  = out_drid_q;
    out_line_d  = out_line_q;
    if (pop && !head_pf) begin
      out_valid_d = 1'b1;
      out_drid_d  = q_drid_q[rd_ptr_q];
      out_line_d  = rd_line;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_drid_q[i] <= '0;
        q_idx_q[i]  <= '0;
        q_pf_q[i]   <= 1'b0;
        q_cnt_q[i]  <= 4'd0;
      end
      for (int j = 0; j < MEM_LINES; j++) begin
        mem_q[j] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_drid_q  <= '0;
      out_line_q  <= '0;
    end else begin
      q_drid_q    <= q_drid_d;
      q_idx_q     <= q_idx_d;
      q_pf_q      <= q_pf_d;
      q_cnt_q     <= q_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_drid_q  <= out_drid_d;
      out_line_q  <= out_line_d;
    end
  end

  assign drtomem_req_retry = full;
  assign drtomem_wb_retry  = 1'b0;
`ifdef DR_MEM_RESPONDER_PFREQ_EN
  assign drtomem_pfreq_retry = full || drtomem_req_valid;
`else
  assign drtomem_pfreq_retry = 1'b0;
`endif
  assign memtodr_ack_valid = out_valid_q;
  assign memtodr_ack_drid  = out_drid_q;
  assign memtodr_ack_ack   = out_valid_q ? ACK_VAL : '0;
  assign memtodr_ack_line  = out_line_q;

  // Command and the address bits outside the line index are not interpreted.
  assign unused_bits = ^{drtomem_req_cmd, drtomem_req_paddr, drtomem_wb_paddr,
                         drtomem_pfreq_paddr, drtomem_pfreq_valid};
endmodule

// File: tb/tb_dr_mem_responder.sv
// tb_dr_mem_responder: scoreboard bench; expected acks are pushed at request acceptance
// from a line-store model and popped by an independent monitor on each ack handshake.
`timescale 1ns/1ps
module tb_dr_mem_responder;
  localparam int LAT      = 4;
  localparam int QDEPTH   = 4;
  localparam int ACK_CODE = 5;

  typedef struct packed {
    logic [5:0]   drid;
    logic [511:0] line;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_retry;
  logic [5:0]   req_drid;
  logic [4:0]   req_cmd;
  logic [49:0]  req_paddr;
  logic         ack_valid, ack_retry;
  logic [5:0]   ack_drid;
  logic [2:0]   ack_ack;
  logic [511:0] ack_line;
  logic         wb_valid, wb_retry;
  logic [511:0] wb_line;
  logic [49:0]  wb_paddr;
  logic         pf_valid, pf_retry;
  logic [49:0]  pf_paddr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acks = 0;
  int retry_mode = 0;
  exp_t sb[$];
  logic [511:0] mem_m [16];

  dr_mem_responder #(.LAT(LAT), .QDEPTH(QDEPTH), .MEM_LINES(16), .ACK_CODE(ACK_CODE)) dut (
    .clk(clk), .reset(reset),
    .drtomem_req_valid(req_valid), .drtomem_req_retry(req_retry),
    .drtomem_req_drid(req_drid), .drtomem_req_cmd(req_cmd), .drtomem_req_paddr(req_paddr),
    .memtodr_ack_valid(ack_valid), .memtodr_ack_retry(ack_retry),
    .memtodr_ack_drid(ack_drid), .memtodr_ack_ack(ack_ack), .memtodr_ack_line(ack_line),
    .drtomem_wb_valid(wb_valid), .drtomem_wb_retry(wb_retry),
    .drtomem_wb_line(wb_line), .drtomem_wb_paddr(wb_paddr),
    .drtomem_pfreq_valid(pf_valid), .drtomem_pfreq_retry(pf_retry),
    .drtomem_pfreq_paddr(pf_paddr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    case (retry_mode)
      0:       ack_retry = 1'b0;
      1:       ack_retry = 1'b1;
      default: ack_retry = ($urandom_range(0, 2) == 0);
    endcase
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event_within_bound", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic do_req(input logic [5:0] d, input logic [49:0] a, output int acc);
    int n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_drid  = d;
    req_paddr = a;
    req_cmd   = 5'($urandom());
    while (req_retry && n < 300) begin
      tick();
      n++;
    end
    if (req_retry) begin
      fail_to("req_accept");
      acc = cyc;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    e.drid = d;
    e.line = mem_m[a[9:6]];
    sb.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [49:0] a, input logic [511:0] l);
    wb_valid = 1'b1;
    wb_paddr = a;
    wb_line  = l;
    #1;
    check("wb_retry", 512'(wb_retry), 512'd0);
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    mem_m[a[9:6]] = l;
  endtask

  task automatic wait_ack(output int c);
    int n;
    n = 0;
    c = -1;
    while (n < 40) begin
      @(negedge clk);
      if (ack_valid) begin
        c = cyc;
        break;
      end
      n++;
    end
    if (c < 0) fail_to("ack_wait");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ack_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || ack_valid) fail_to("drain");
    tick();
  endtask

  // Monitor: pops the scoreboard on every ack transfer and checks stall stability.
  logic         prev_stall = 1'b0;
  logic [5:0]   prev_drid;
  logic [511:0] prev_line;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 512'(ack_valid), 512'd1);
        check("stall_drid", 512'(ack_drid), 512'(prev_drid));
        check("stall_line", ack_line, prev_line);
      end
      if (ack_valid && !ack_retry) begin
        acks++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual=drid_%0d required=no_ack", ack_drid);
        end else begin
          e = sb.pop_front();
          check("ack_drid", 512'(ack_drid), 512'(e.drid));
          check("ack_line", ack_line, e.line);
          check("ack_code", 512'(ack_ack), 512'(ACK_CODE));
        end
      end
`ifndef DR_MEM_RESPONDER_PFREQ_EN
      check("pfreq_retry_zero", 512'(pf_retry), 512'd0);
`endif
      prev_stall = ack_valid && ack_retry;
      prev_drid  = ack_drid;
      prev_line  = ack_line;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c, pf_acc, n_wb, n_rq, acks_before;
    logic [49:0] a;
    reset = 1'b1;
    req_valid = 1'b0; req_drid = '0; req_cmd = '0; req_paddr = '0;
    wb_valid = 1'b0; wb_line = '0; wb_paddr = '0;
    pf_valid = 1'b0; pf_paddr = '0;
    ack_retry = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_valid", 512'(ack_valid), 512'd0);
    check("rst_ack_drid", 512'(ack_drid), 512'd0);
    check("rst_ack_line", ack_line, 512'd0);
    check("rst_req_retry", 512'(req_retry), 512'd0);
    check("rst_pf_retry", 512'(pf_retry), 512'd0);
    reset = 1'b0;
    tick();

    // Latency from an idle queue.
    while (cyc < 9) tick();
    do_req(6'd5, 50'h1C0, acc);
    check("latency_accept_cycle", 512'(acc), 512'd10);
    wait_ack(c);
    check("latency", 512'(c - acc), 512'(LAT));
    drain();

    // Writeback then read, then writeback landing in the pop cycle.
    do_wb(50'h80, {64{8'hA5}});
    do_req(6'd3, 50'h80, acc);
    drain();
    mem_m[2] = {64{8'h5A}};
    do_req(6'd4, 50'h80, acc);
    repeat (LAT - 1) tick();
    wb_valid = 1'b1; wb_paddr = 50'h80; wb_line = {64{8'h5A}};
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    wait_ack(c);
    check("bypass_latency", 512'(c - acc), 512'(LAT));
    drain();

    // Fill under backpressure.
    retry_mode = 1;
    tick(); tick();
    for (int i = 1; i <= 4; i++) do_req(6'(i), 50'(i) << 6, acc);
    check("full_after_4", 512'(req_retry), 512'd1);
    do_req(6'd5, 50'h140, acc);
    check("full_after_5", 512'(req_retry), 512'd1);
    repeat (6) tick();
    retry_mode = 0;
    drain();

    // req and pfreq valid together.
    req_valid = 1'b1; req_drid = 6'd6; req_paddr = 50'h100; pf_valid = 1'b1; pf_paddr = 50'h40;
    #1;
`ifdef DR_MEM_RESPONDER_PFREQ_EN
    check("prio_pf_retry", 512'(pf_retry), 512'd1);
`else
    check("prio_pf_retry", 512'(pf_retry), 512'd0);
`endif
    check("prio_req_retry", 512'(req_retry), 512'd0);
    @(posedge clk);
    #1;
    sb.push_back('{drid: 6'd6, line: mem_m[4]});
    req_valid = 1'b0;
    tick();
    pf_valid = 1'b0;
    drain();
    repeat (LAT + 2) tick();

    // pfreq followed by req.
    pf_valid = 1'b1; pf_paddr = 50'h200;
    #1;
    check("pf_idle_retry", 512'(pf_retry), 512'd0);
    @(posedge clk);
    #1;
    pf_acc = cyc;
    pf_valid = 1'b0;
    do_req(6'd7, 50'h240, acc);
    wait_ack(c);
`ifdef DR_MEM_RESPONDER_PFREQ_EN
    check("pf_then_req_latency", 512'(c - pf_acc), 512'(LAT + 1));
`else
    check("pf_then_req_latency", 512'(c - acc), 512'(LAT));
`endif
    drain();

    // Randomized epochs: writebacks first, then reads with random backpressure.
    for (int ep = 0; ep < 25; ep++) begin
      n_wb = $urandom_range(1, 3);
      for (int k = 0; k < n_wb; k++) begin
        a = 50'({$urandom(), $urandom()});
        do_wb(a, rand_line());
      end
      retry_mode = 2;
      n_rq = $urandom_range(1, 8);
      for (int k = 0; k < n_rq; k++) begin
        pf_valid = 1'($urandom_range(0, 1));
        pf_paddr = 50'({$urandom(), $urandom()});
        a = 50'({$urandom(), $urandom()});
        do_req(6'($urandom()), a, acc);
        pf_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      retry_mode = 0;
      repeat (LAT + 2) tick();
    end

    // Reset with three requests in flight.
    do_wb(50'h80, {64{8'hC3}});
    do_req(6'd9, 50'h80, acc);
    do_req(6'd10, 50'h80, acc);
    do_req(6'd11, 50'h80, acc);
    reset = 1'b1;
    #1;
    check("midrst_ack_valid", 512'(ack_valid), 512'd0);
    check("midrst_ack_drid", 512'(ack_drid), 512'd0);
    check("midrst_ack_line", ack_line, 512'd0);
    check("midrst_req_retry", 512'(req_retry), 512'd0);
    check("midrst_pf_retry", 512'(pf_retry), 512'd0);
    sb.delete();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    tick();
    reset = 1'b0;
    acks_before = acks;
    repeat (12) tick();
    check("no_ack_after_reset", 512'(acks - acks_before), 512'd0);
    do_req(6'd12, 50'h80, acc);
    wait_ack(c);
    check("post_reset_latency", 512'(c - acc), 512'(LAT));
    drain();
    check("scoreboard_empty", 512'(sb.size()), 512'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
